interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The module SHALL have parameter NUM_SRC, default 16, meaning the number of interrupt sources; index width is fixed at 4 bits.
REQ-002 The module SHALL have port clk, input, 1, the single system clock (25 MHz CPU clock domain).
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port irqSignal, input, 1, interrupt strobe from a device; a rising edge raises one event.
REQ-005 The module SHALL have port irqIndex, input, 4, source index of the event, valid while irqSignal is high.
REQ-006 The module SHALL have port maskWe, input, 1, mask write enable.
REQ-007 The module SHALL have port maskData, input, 16, new mask; bit i = 1 enables source i.
REQ-008 The module SHALL have port cpuAck, input, 1, CPU accepts the offered interrupt.
REQ-009 The module SHALL have port cpuEoi, input, 1, CPU end-of-interrupt pulse.
REQ-010 The module SHALL have port cpuIrq, output, 1, registered interrupt request to the CPU.
REQ-011 The module SHALL have port cpuIrqIndex, output, 4, registered index of the offered or in-service source.
REQ-012 The module SHALL have ports maskValue (output, 16, current mask), pendingValue (output, 16, pending bits) and lostIrq (output, 1, sticky lost-event flag).

Function
REQ-013 Edge detect: an event SHALL be registered on the clk edge where the sampled irqSignal is 1 and the previous sample was 0; pending[irqIndex] is set on that edge.
REQ-014 A level held high SHALL produce exactly one event; indexes >= NUM_SRC SHALL be ignored.
REQ-015 An event on a source whose pending bit is already set SHALL set lostIrq; lostIrq SHALL clear only on cpuEoi or reset.
REQ-016 The FSM SHALL have states IDLE, REQUEST and SERVICE.
REQ-017 IDLE: if (pending & mask) != 0, at the next edge go to REQUEST, set cpuIrq=1, cpuIrqIndex = lowest set index (index 0 highest priority).
REQ-018 REQUEST: cpuIrqIndex SHALL be held stable; on cpuAck=1 clear pending[cpuIrqIndex], set cpuIrq=0, go to SERVICE.
REQ-019 REQUEST: if the offered source becomes masked before ack, go to IDLE with cpuIrq=0 and the pending bit retained.
REQ-020 SERVICE: cpuIrq SHALL stay 0 and cpuIrqIndex hold; on cpuEoi=1 go to IDLE. No nesting.
REQ-021 A new event on the same source in the same cycle as its ack clear SHALL leave the pending bit set (set wins).
REQ-022 maskWe=1 SHALL load maskData into the mask at the clk edge; the new mask applies from the following cycle.
REQ-023 cpuAck outside REQUEST and cpuEoi outside SERVICE SHALL be ignored, except that cpuEoi SHALL always clear lostIrq.
REQ-024 Minimum latency from the irqSignal rising-edge sample to cpuIrq=1 SHALL be 2 cycles without synchronizer.

Reset
REQ-025 While rst=0: state IDLE, pending=0, mask=16'hFFFF, cpuIrq=0, cpuIrqIndex=0, lostIrq=0, edge-detect history=0.
REQ-026 Reset mid-REQUEST or mid-SERVICE SHALL abandon the interrupt with no residual pending bit.

Configuration
REQ-027 With INTC_SYNC_EN defined, irqSignal and irqIndex SHALL pass through a two-flop synchronizer before edge detection, adding 2 cycles to all event latencies (REQ-024 becomes 4).
REQ-028 Without INTC_SYNC_EN, the inputs SHALL feed edge detection directly.

Structure
REQ-029 FSM state encodings, NUM_SRC default and the reset mask constant SHALL live in shared package intc_pkg.
REQ-030 The lowest-set-bit priority encoder SHALL be sub-module intc_priority_enc (16-bit vector in, 4-bit index and any-valid out).

Verification
REQ-031 Reset, then irqSignal 0->1 with irqIndex=3 -> pendingValue=16'h0008, cpuIrq=1 with index 3 two cycles later (four with INTC_SYNC_EN).
REQ-032 Events on 5 and 2 before ack -> index 2 offered first; after ack+EOI index 5 offered.
REQ-033 maskData=16'hFFF7 written during REQUEST for index 3 -> cpuIrq drops, pending bit 3 kept; remask FFFF -> re-offered.
REQ-034 Second event on index 3 while pending -> lostIrq=1; cpuEoi -> lostIrq=0.
REQ-035 Event on index 4 in same cycle as cpuAck for index 4 -> pendingValue bit 4 remains 1.
REQ-036 rst=0 asserted in SERVICE -> all outputs at reset values same cycle; no request after release.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default source count, index width and the reset mask.
package intc_pkg;

  localparam int          NUM_SRC_DEFAULT = 16;
  localparam int          IDX_W           = 4;
  localparam logic [15:0] MASK_RESET      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } intcState_t;

endpackage

// File: rtl/intc_priority_enc.sv
// Lowest-set-bit priority encoder (bit 0 has the highest priority).
// Ports:
//   vec   - 16-bit request vector
//   idx   - index of the lowest set bit (0 when none set)
//   valid - 1 when any bit of vec is set
module intc_priority_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top so the last assignment is the lowest set bit.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detected interrupt events from a device strobe,
// per-source pending bits, a programmable enable mask, and a simple
// offer / acknowledge / end-of-interrupt handshake with the CPU (no nesting).
//
// Build option: define INTC_SYNC_EN to pass irqSignal/irqIndex through a
// two-flop synchronizer before edge detection (adds 2 cycles of latency).
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   irqSignal    - device interrupt strobe, rising edge raises one event
//   irqIndex     - source index of the event, valid while irqSignal is high
//   maskWe       - mask write enable
//   maskData     - new mask, bit i = 1 enables source i
//   cpuAck       - CPU accepts the offered interrupt
//   cpuEoi       - CPU end-of-interrupt pulse (also clears lostIrq)
//   cpuIrq       - registered interrupt request to the CPU
//   cpuIrqIndex  - registered index of the offered / in-service source
//   maskValue    - current mask
//   pendingValue - pending bits
//   lostIrq      - sticky flag: an event hit an already-pending source
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irqSignal,
  input  logic [3:0]  irqIndex,
  input  logic        maskWe,
  input  logic [15:0] maskData,
  input  logic        cpuAck,
  input  logic        cpuEoi,
  output logic        cpuIrq,
  output logic [3:0]  cpuIrqIndex,
  output logic [15:0] maskValue,
  output logic [15:0] pendingValue,
  output logic        lostIrq
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // IDLE    | nothing offered; offer lowest enabled pending source
  // REQUEST | cpuIrq high, index held; wait for ack or offered source masked
  // SERVICE | CPU handling the source; wait for end-of-interrupt

  intcState_t  state;
  logic [15:0] pending;
  logic [15:0] mask;
  logic        edgeSig;
  logic [3:0]  edgeIdx;
  logic        sigPrev;
  logic        irqEvent;
  logic [15:0] setVec;
  logic [15:0] clrVec;
  logic        ackTake;
  logic        lostNew;
  logic [3:0]  encIdx;
  logic        encValid;

`ifdef INTC_SYNC_EN
  logic       sigS1, sigS2;
  logic [3:0] idxS1, idxS2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sigS1 <= 1'b0;
      sigS2 <= 1'b0;
      idxS1 <= '0;
      idxS2 <= '0;
    end else begin
      sigS1 <= irqSignal;
      sigS2 <= sigS1;
      idxS1 <= irqIndex;
      idxS2 <= idxS1;
    end
  end

  assign edgeSig = sigS2;
  assign edgeIdx = idxS2;
`else
  assign edgeSig = irqSignal;
  assign edgeIdx = irqIndex;
`endif

  assign irqEvent = edgeSig & ~sigPrev & (int'(edgeIdx) < NUM_SRC);
  assign setVec   = irqEvent ? (16'd1 << edgeIdx) : '0;

  // The ack only counts while the offered source is still enabled; a masked
  // offer is withdrawn instead and keeps its pending bit.
  assign ackTake  = (state == REQUEST) & mask[cpuIrqIndex] & cpuAck;
  assign clrVec   = ackTake ? (16'd1 << cpuIrqIndex) : '0;

  // An event that coincides with the ack of its own source is not lost: the
  // old occurrence has just been accepted and the new one re-arms the bit.
  assign lostNew  = irqEvent & |(pending & ~clrVec & setVec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sigPrev <= 1'b0;
      pending <= '0;
      mask    <= MASK_RESET;
      lostIrq <= 1'b0;
    end else begin
      sigPrev <= edgeSig;
      pending <= (pending & ~clrVec) | setVec;
      lostIrq <= (lostIrq & ~cpuEoi) | lostNew;
      if (maskWe)
        mask <= maskData;
    end
  end

  intc_priority_enc uEnc (
    .vec   (pending & mask),
    .idx   (encIdx),
    .valid (encValid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cpuIrq      <= 1'b0;
      cpuIrqIndex <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (encValid) begin
            state       <= REQUEST;
            cpuIrq      <= 1'b1;
            cpuIrqIndex <= encIdx;
          end
        end
        REQUEST: begin
          if (!mask[cpuIrqIndex]) begin
            state  <= IDLE;
            cpuIrq <= 1'b0;
          end else if (cpuAck) begin
            state  <= SERVICE;
            cpuIrq <= 1'b0;
          end
        end
        SERVICE: begin
          if (cpuEoi)
            state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          cpuIrq <= 1'b0;
        end
      endcase
    end
  end

  assign maskValue    = mask;
  assign pendingValue = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios followed by random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_interrupt_controller;

  localparam int NSRC = 12;
`ifdef INTC_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = 2 + SYNC_D;

  logic        clk = 1'b0;
  logic        rst;
  logic        irqSignal;
  logic [3:0]  irqIndex;
  logic        maskWe;
  logic [15:0] maskData;
  logic        cpuAck;
  logic        cpuEoi;
  logic        cpuIrq;
  logic [3:0]  cpuIrqIndex;
  logic [15:0] maskValue;
  logic [15:0] pendingValue;
  logic        lostIrq;

  always #20 clk = ~clk;

  interrupt_controller #(.NUM_SRC(NSRC)) dut (
    .clk          (clk),
    .rst          (rst),
    .irqSignal    (irqSignal),
    .irqIndex     (irqIndex),
    .maskWe       (maskWe),
    .maskData     (maskData),
    .cpuAck       (cpuAck),
    .cpuEoi       (cpuEoi),
    .cpuIrq       (cpuIrq),
    .cpuIrqIndex  (cpuIrqIndex),
    .maskValue    (maskValue),
    .pendingValue (pendingValue),
    .lostIrq      (lostIrq)
  );

  int nAssert = 0;
  int nFail   = 0;

  // Behavioural model: which sources are waiting, which one the CPU is being
  // offered, and whether the CPU is busy with one.
  bit [15:0] mPend;
  bit [15:0] mMask;
  bit        mOffered;
  bit        mBusy;
  bit [3:0]  mIdx;
  bit        mLost;
  bit        mLastSig;
  bit        mDlySig [2];
  bit [3:0]  mDlyIdx [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowestSet(input bit [15:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mPend    = '0;
    mMask    = 16'hFFFF;
    mOffered = 0;
    mBusy    = 0;
    mIdx     = '0;
    mLost    = 0;
    mLastSig = 0;
    for (int i = 0; i < 2; i++) begin
      mDlySig[i] = 0;
      mDlyIdx[i] = '0;
    end
  endtask

  task automatic modelStep();
    bit       sig;
    bit [3:0] idx;
    bit       newEvent;
    int       accepted;
    bit       wasPending;
    accepted = -1;
    if (SYNC_D > 0) begin
      sig = mDlySig[1];
      idx = mDlyIdx[1];
      mDlySig[1] = mDlySig[0];
      mDlyIdx[1] = mDlyIdx[0];
      mDlySig[0] = irqSignal;
      mDlyIdx[0] = irqIndex;
    end else begin
      sig = irqSignal;
      idx = irqIndex;
    end
    newEvent = sig && !mLastSig && (int'(idx) < NSRC);
    mLastSig = sig;

    if (mBusy) begin
      if (cpuEoi) mBusy = 0;
    end else if (mOffered) begin
      if (mMask[mIdx] == 1'b0) mOffered = 0;
      else if (cpuAck) begin
        accepted = int'(mIdx);
        mOffered = 0;
        mBusy    = 1;
      end
    end else if ((mPend & mMask) != 0) begin
      mOffered = 1;
      mIdx     = 4'(lowestSet(mPend & mMask));
    end

    if (accepted >= 0) mPend[accepted] = 0;
    wasPending = newEvent && mPend[idx];
    if (cpuEoi) mLost = 0;
    if (wasPending) mLost = 1;
    if (newEvent) mPend[idx] = 1;
    if (maskWe) mMask = maskData;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    check("cpuIrq",       16'(cpuIrq),      16'(mOffered));
    check("cpuIrqIndex",  16'(cpuIrqIndex), 16'(mIdx));
    check("maskValue",    maskValue,        mMask);
    check("pendingValue", pendingValue,     mPend);
    check("lostIrq",      16'(lostIrq),     16'(mLost));
  endtask

  task automatic pulse(input int idx);
    irqSignal = 1'b1;
    irqIndex  = 4'(idx);
    tick();
    irqSignal = 1'b0;
    tick();
  endtask

  task automatic waitIrq(input string tag);
    int n = 0;
    while (cpuIrq !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 16'(cpuIrq), 16'd1);
  endtask

  task automatic ackEoi();
    cpuAck = 1'b1;
    tick();
    cpuAck = 1'b0;
    cpuEoi = 1'b1;
    tick();
    cpuEoi = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_irq"},  16'(cpuIrq),      16'd0);
    check({tag, "_idx"},  16'(cpuIrqIndex), 16'd0);
    check({tag, "_mask"}, maskValue,        16'hFFFF);
    check({tag, "_pend"}, pendingValue,     16'h0000);
    check({tag, "_lost"}, 16'(lostIrq),     16'd0);
  endtask

  initial begin
    rst       = 1'b0;
    irqSignal = 1'b0;
    irqIndex  = '0;
    maskWe    = 1'b0;
    maskData  = '0;
    cpuAck    = 1'b0;
    cpuEoi    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b1;

    // First event on source 3: latency and single event from a held level
    irqSignal = 1'b1;
    irqIndex  = 4'd3;
    repeat (LAT - 1) tick();
    check("lat_early_irq", 16'(cpuIrq), 16'd0);
    tick();
    check("lat_irq",  16'(cpuIrq),      16'd1);
    check("lat_idx",  16'(cpuIrqIndex), 16'd3);
    check("lat_pend", pendingValue,     16'h0008);
    repeat (3) tick();
    check("level_once_lost", 16'(lostIrq), 16'd0);
    irqSignal = 1'b0;
    tick();

    // Second event on pending source 3 -> lost; EOI clears it
    irqSignal = 1'b1;
    tick();
    irqSignal = 1'b0;
    repeat (SYNC_D + 1) tick();
    check("lost_set", 16'(lostIrq), 16'd1);
    cpuAck = 1'b1;
    tick();
    cpuAck = 1'b0;
    check("ack_irq_low", 16'(cpuIrq),  16'd0);
    check("ack_pend",    pendingValue, 16'h0000);
    cpuEoi = 1'b1;
    tick();
    cpuEoi = 1'b0;
    check("lost_clr", 16'(lostIrq), 16'd0);

    // Index at or above NUM_SRC is ignored
    pulse(13);
    repeat (SYNC_D + 2) tick();
    check("ignore_pend", pendingValue,     16'h0000);
    check("ignore_irq",  16'(cpuIrq),      16'd0);

    // Sources 5 and 2 pending together -> 2 first, then 5
    maskWe   = 1'b1;
    maskData = 16'h0000;
    tick();
    maskWe = 1'b0;
    pulse(5);
    pulse(2);
    repeat (SYNC_D + 1) tick();
    check("prio_pend", pendingValue, 16'h0024);
    maskWe   = 1'b1;
    maskData = 16'hFFFF;
    tick();
    maskWe = 1'b0;
    waitIrq("prio_first_wait");
    check("prio_first_idx", 16'(cpuIrqIndex), 16'd2);
    ackEoi();
    waitIrq("prio_second_wait");
    check("prio_second_idx", 16'(cpuIrqIndex), 16'd5);
    ackEoi();

    // Masking the offered source withdraws the offer, keeps pending
    pulse(3);
    waitIrq("mask_offer_wait");
    check("mask_offer_idx", 16'(cpuIrqIndex), 16'd3);
    maskWe   = 1'b1;
    maskData = 16'hFFF7;
    tick();
    maskWe = 1'b0;
    check("mask_delay_irq", 16'(cpuIrq), 16'd1);
    tick();
    check("mask_drop_irq",  16'(cpuIrq),  16'd0);
    check("mask_drop_pend", pendingValue, 16'h0008);
    maskWe   = 1'b1;
    maskData = 16'hFFFF;
    tick();
    maskWe = 1'b0;
    waitIrq("remask_wait");
    check("remask_idx", 16'(cpuIrqIndex), 16'd3);
    ackEoi();

    // New event on 4 on the same edge as the ack of 4 -> bit stays set
    pulse(4);
    waitIrq("same_cycle_wait");
    irqSignal = 1'b1;
    irqIndex  = 4'd4;
    repeat (SYNC_D) tick();
    cpuAck = 1'b1;
    tick();
    cpuAck    = 1'b0;
    irqSignal = 1'b0;
    check("same_cycle_pend", pendingValue, 16'h0010);
    check("same_cycle_irq",  16'(cpuIrq),  16'd0);
    cpuEoi = 1'b1;
    tick();
    cpuEoi = 1'b0;
    waitIrq("same_cycle_reoffer");
    check("same_cycle_idx", 16'(cpuIrqIndex), 16'd4);
    ackEoi();

    // Reset while in SERVICE
    pulse(6);
    waitIrq("svc_reset_wait");
    cpuAck = 1'b1;
    tick();
    cpuAck = 1'b0;
    pulse(9);
    rst = 1'b0;
    #1;
    checkResetOutputs("svc_reset");
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (LAT + 2) tick();
    check("post_reset_irq",  16'(cpuIrq),  16'd0);
    check("post_reset_pend", pendingValue, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      irqSignal = ($urandom_range(0, 2) == 0);
      irqIndex  = 4'($urandom_range(0, 15));
      maskWe    = ($urandom_range(0, 19) == 0);
      maskData  = 16'($urandom) | 16'($urandom);
      cpuAck    = ($urandom_range(0, 2) == 0);
      cpuEoi    = ($urandom_range(0, 3) == 0);
      tick();
    end
    irqSignal = 1'b0;
    maskWe    = 1'b0;
    cpuAck    = 1'b0;
    cpuEoi    = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
